// File: rtl/frame_accum_bcd_display_pkg.sv
// Shared seven-segment types, segment table, FSM states and sizing helpers
// for the frame accumulator display path.
package seg7_pkg;

   typedef logic [6:0] seg7_t;
   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {ACCUM, CONVERT, OUTPUT} state_t;

   localparam seg7_t SEG7_BLANK = 7'b0000000;

   // Segment order a..g from bit 6 down to bit 0
   localparam seg7_t SEG7_LUT [10] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011
   };

   function automatic logic [63:0] pow10(input int d);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < d; i++) p = p * 64'd10;
      return p;
   endfunction

   // Decimal digits needed to hold any wsum-bit value, never fewer than d
   function automatic int bcd_digits(input int wsum, input int d);
      int need;
      need = (wsum * 30103 + 99999) / 100000 + 1;
      return (need > d) ? need : d;
   endfunction

   function automatic seg7_t seg7_encode(input bcd_t digit);
      return (digit <= 4'd9) ? SEG7_LUT[digit] : SEG7_BLANK;
   endfunction

endpackage

// File: rtl/frame_accum_bcd_display_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter: one iteration per cycle,
// WIN iterations after the start cycle loads the operand.
module bin2bcd_seq
   import seg7_pkg::*;
#(
   parameter int WIN  = 12,
   parameter int DOUT = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIN-1:0]    bin,
   output logic              busy,
   output logic              done,
   output logic [4*DOUT-1:0] bcd
);

   localparam int NW = bcd_digits(WIN, DOUT);
   localparam int IW = (WIN > 1) ? $clog2(WIN) : 1;

   logic [WIN-1:0]  shreg;
   logic [4*NW-1:0] work;
   logic [4*NW-1:0] adj;
   logic [IW-1:0]   iter;

   always_comb begin
      adj = work;
      for (int i = 0; i < NW; i++) begin
         if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
   end

   assign done = busy && (iter == IW'(WIN - 1));
   assign bcd  = work[4*DOUT-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         iter  <= '0;
         shreg <= '0;
         work  <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         iter  <= '0;
         shreg <= bin;
         work  <= '0;
      end else if (busy) begin
         work  <= {adj[4*NW-2:0], shreg[WIN-1]};
         shreg <= shreg << 1;
         iter  <= iter + IW'(1);
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/frame_accum_bcd_display.sv
// Frame accumulator feeding a BCD converter and seven-segment encoder with
// overflow saturation and optional leading-zero blanking.
module frame_accum_bcd_display
   import seg7_pkg::*;
#(
   parameter int W              = 8,
   parameter int N              = 16,
   parameter int D              = 4,
   parameter int BLANK_LZ       = 1,
   parameter int SEG_ACTIVE_LOW = 0
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [W-1:0]       s_data,
   input  logic               s_valid,
   input  logic               s_last,
   output logic               s_ready,
   output logic [D-1:0][6:0]  m_data,
   output logic               m_ovf,
   output logic               m_valid,
   input  logic               m_ready
);

   localparam int          W_SUM     = W + $clog2(N);
   localparam int          CW        = $clog2(N);
   localparam logic [63:0] OVF_LIMIT = pow10(D) - 64'd1;

   state_t            state;
   state_t            state_next;
   logic [CW-1:0]     cnt;
   logic [W_SUM-1:0]  sum;
   logic              ovf;
   logic              accept;
   logic              frame_end;
   logic              start;
   logic              busy;
   logic              done;
   logic [4*D-1:0]    bcd;
   logic              seen;
   bcd_t              digit;
   seg7_t             seg;

   assign accept    = s_valid && s_ready;
   assign frame_end = s_last || (cnt == CW'(N - 1));
   assign m_ovf     = ovf;

   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      start      = 1'b0;
      case (state)
         ACCUM: begin
            s_ready = !rst;
            if (s_valid && !rst && frame_end) state_next = CONVERT;
         end
         CONVERT: begin
            start = !busy;
            if (done) state_next = OUTPUT;
         end
         OUTPUT: begin
            m_valid = !rst;
            if (m_ready) state_next = ACCUM;
         end
         default: state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
         cnt   <= '0;
         sum   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            sum <= (cnt == '0) ? W_SUM'(s_data) : sum + W_SUM'(s_data);
            cnt <= frame_end ? '0 : cnt + CW'(1);
         end
         // Start cycle sees the completed frame sum
         if (start) ovf <= (64'(sum) > OVF_LIMIT);
      end
   end

   bin2bcd_seq #(
      .WIN  (W_SUM),
      .DOUT (D)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (sum),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   // Walk from the top digit down so blanking stops at the first nonzero digit
   always_comb begin
      seen   = 1'b0;
      digit  = '0;
      seg    = SEG7_BLANK;
      m_data = '0;
      for (int i = D - 1; i >= 0; i--) begin
         digit = bcd[4*i +: 4];
         seen  = seen | (digit != 4'd0);
         if (ovf)                                     seg = SEG7_LUT[9];
         else if ((BLANK_LZ != 0) && !seen && i != 0) seg = SEG7_BLANK;
         else                                         seg = seg7_encode(digit);
         if (state != OUTPUT) seg = SEG7_BLANK;
         m_data[i] = (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
      end
   end

endmodule

// File: tb/tb_frame_accum_bcd_display.sv
// Self-checking bench: three configurations (default, D=2, active-low
// segments) share one stimulus bus selected by sel.
module tb_frame_accum_bcd_display;

   localparam int W = 8;
   localparam int N = 16;
   localparam int LATENCY = W + $clog2(N) + 1;

   localparam logic [6:0] SEG_REF [10] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011
   };

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] s_data;
   logic         s_valid;
   logic         s_last;
   logic         m_ready;
   int           sel;

   logic              sr0, mv0, mo0;
   logic              sr1, mv1, mo1;
   logic              sr2, mv2, mo2;
   logic [3:0][6:0]   md0;
   logic [1:0][6:0]   md1;
   logic [3:0][6:0]   md2;

   logic        ready_o;
   logic        valid_o;
   logic        ovf_o;
   logic [55:0] data_o;

   int checks   = 0;
   int failures = 0;
   int frame_q[$];

   always #5 clk = ~clk;

   frame_accum_bcd_display #(.W(W), .N(N), .D(4), .BLANK_LZ(1), .SEG_ACTIVE_LOW(0)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid && sel == 0), .s_last(s_last),
      .s_ready(sr0), .m_data(md0), .m_ovf(mo0), .m_valid(mv0), .m_ready(m_ready && sel == 0));

   frame_accum_bcd_display #(.W(W), .N(N), .D(2), .BLANK_LZ(1), .SEG_ACTIVE_LOW(0)) dut_d2 (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid && sel == 1), .s_last(s_last),
      .s_ready(sr1), .m_data(md1), .m_ovf(mo1), .m_valid(mv1), .m_ready(m_ready && sel == 1));

   frame_accum_bcd_display #(.W(W), .N(N), .D(4), .BLANK_LZ(1), .SEG_ACTIVE_LOW(1)) dut_al (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid && sel == 2), .s_last(s_last),
      .s_ready(sr2), .m_data(md2), .m_ovf(mo2), .m_valid(mv2), .m_ready(m_ready && sel == 2));

   assign ready_o = (sel == 0) ? sr0 : (sel == 1) ? sr1 : sr2;
   assign valid_o = (sel == 0) ? mv0 : (sel == 1) ? mv1 : mv2;
   assign ovf_o   = (sel == 0) ? mo0 : (sel == 1) ? mo1 : mo2;
   assign data_o  = (sel == 0) ? {28'd0, md0} : (sel == 1) ? {42'd0, md1} : {28'd0, md2};

   // Expected display word from plain decimal arithmetic on the frame sum
   function automatic logic [55:0] modelSeg(input longint sum, input int nd, input bit al);
      logic [55:0] r;
      logic [6:0]  s;
      longint      pw;
      longint      lim;
      bit          ovf;
      int          dig;
      r   = '0;
      lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      ovf = (sum >= lim);
      pw  = 1;
      for (int i = 0; i < nd; i++) begin
         dig = ovf ? 9 : int'((sum / pw) % 10);
         s   = SEG_REF[dig];
         if (!ovf && i > 0 && sum < pw) s = 7'b0000000;
         if (al) s = ~s;
         r[7*i +: 7] = s;
         pw = pw * 10;
      end
      return r;
   endfunction

   function automatic longint frameSum();
      longint s;
      s = 0;
      foreach (frame_q[i]) s += frame_q[i];
      return s;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives frame_q with random idle gaps; s_last toggles freely while idle
   task automatic applyStimulus(input bit use_last, input int max_gap);
      int gap;
      for (int i = 0; i < frame_q.size(); i++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         repeat (gap) begin
            s_valid = 1'b0;
            s_data  = W'($urandom);
            s_last  = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
         end
         s_valid = 1'b1;
         s_data  = W'(frame_q[i]);
         s_last  = use_last && (i == frame_q.size() - 1);
         @(negedge clk);
         checkOutput("s_ready_accum", 64'(ready_o), 64'd1);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Waits for the display word, checks latency/content, holds, then hands off
   task automatic awaitResult(input int hold);
      longint      sum;
      int          nd;
      int          edges;
      logic [55:0] exp_data;
      sum      = frameSum();
      nd       = (sel == 1) ? 2 : 4;
      exp_data = modelSeg(sum, nd, sel == 2);
      edges    = 0;
      while (valid_o !== 1'b1 && edges < 100) begin
         checkOutput("s_ready_convert", 64'(ready_o), 64'd0);
         @(posedge clk); #1;
         edges++;
      end
      checkOutput("latency", 64'(edges), 64'(LATENCY));
      checkOutput("m_data", 64'(data_o), 64'(exp_data));
      checkOutput("m_ovf", 64'(ovf_o), (sum > (nd == 2 ? 99 : 9999)) ? 64'd1 : 64'd0);
      for (int h = 0; h < hold; h++) begin
         s_valid = 1'b1;
         s_data  = W'($urandom);
         s_last  = 1'($urandom_range(1, 0));
         @(negedge clk);
         checkOutput("hold_m_valid", 64'(valid_o), 64'd1);
         checkOutput("hold_m_data", 64'(data_o), 64'(exp_data));
         checkOutput("hold_s_ready", 64'(ready_o), 64'd0);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      checkOutput("release_m_valid", 64'(valid_o), 64'd1);
      checkOutput("release_s_ready", 64'(ready_o), 64'd0);
      @(posedge clk); #1;
      m_ready = 1'b0;
      checkOutput("after_xfer_s_ready", 64'(ready_o), 64'd1);
      checkOutput("after_xfer_m_valid", 64'(valid_o), 64'd0);
   endtask

   task automatic randomFrame(input int maxv);
      int len;
      bit use_last;
      len      = int'($urandom_range(N, 1));
      use_last = (len < N) ? 1'b1 : 1'($urandom_range(1, 0));
      frame_q.delete();
      repeat (len) frame_q.push_back(int'($urandom_range(maxv, 0)));
      applyStimulus(use_last, 2);
      awaitResult(int'($urandom_range(3, 0)));
   endtask

   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
      sel     = 0;

      // Reset state of every configuration
      repeat (2) @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         sel = k;
         @(negedge clk);
         checkOutput("rst_s_ready", 64'(ready_o), 64'd0);
         checkOutput("rst_m_valid", 64'(valid_o), 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sel = k;
         @(negedge clk);
         checkOutput("post_rst_s_ready", 64'(ready_o), 64'd1);
         checkOutput("post_rst_m_valid", 64'(valid_o), 64'd0);
         checkOutput("post_rst_m_ovf", 64'(ovf_o), 64'd0);
         checkOutput("post_rst_m_data", 64'(data_o), (k == 2) ? 64'hFFFFFFF : 64'd0);
      end
      sel = 0;
      @(posedge clk); #1;

      frame_q = {10, 20, 30, 40};
      applyStimulus(1'b1, 0);
      awaitResult(0);

      frame_q.delete();
      repeat (N) frame_q.push_back(255);
      applyStimulus(1'b0, 1);
      awaitResult(0);

      frame_q = {17, 200, 3, 99, 45};
      applyStimulus(1'b1, 2);
      awaitResult(20);

      // Reset in the middle of a conversion must discard that frame
      frame_q = {250, 250, 250};
      applyStimulus(1'b1, 0);
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_m_valid", 64'(valid_o), 64'd0);
      checkOutput("mid_rst_s_ready", 64'(ready_o), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("after_rst_s_ready", 64'(ready_o), 64'd1);
      checkOutput("after_rst_m_valid", 64'(valid_o), 64'd0);
      checkOutput("after_rst_m_data", 64'(data_o), 64'd0);
      @(posedge clk); #1;
      frame_q = {1, 2, 3};
      applyStimulus(1'b1, 1);
      awaitResult(0);

      for (int f = 0; f < 12; f++) randomFrame(255);

      sel = 1;
      @(posedge clk); #1;
      frame_q = {60, 40};
      applyStimulus(1'b1, 0);
      awaitResult(0);
      frame_q = {5, 4};
      applyStimulus(1'b1, 0);
      awaitResult(0);
      for (int f = 0; f < 4; f++) randomFrame((f % 2 == 0) ? 12 : 255);

      sel = 2;
      @(posedge clk); #1;
      frame_q = {7};
      applyStimulus(1'b1, 0);
      awaitResult(0);
      for (int f = 0; f < 3; f++) randomFrame(255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frame_accum_bcd_display.md
Name: frame_accum_bcd_display

Overview:
- Accumulates frames of up to N unsigned W-bit samples, accepted on a valid/ready stream.
- Converts each frame sum to D BCD digits using a sequential shift-add-3 engine, then presents D seven-segment codes on a valid/ready output.
- Generalises the team's fixed 2-digit accumulator: parametrised digit count, early frame termination, overflow saturation, leading-zero blanking, and a selectable segment polarity.
- Sits between a sample source and the board display driver.

Parameters:
- W, 8, sample width in bits (W >= 1).
- N, 16, maximum samples per frame (N >= 2).
- D, 4, number of decimal digits displayed (1..8).
- BLANK_LZ, 1, when 1, leading-zero digits are blanked.
- SEG_ACTIVE_LOW, 0, when 1, every segment bit is inverted at the output.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- s_data  in  W  sample value.
- s_valid  in  1  sample valid.
- s_last  in  1  ends the frame with this sample; qualified by s_valid.
- s_ready  out  1  block accepts a sample.
- m_data  out  [D-1:0][6:0]  seven-segment codes; digit 0 is the ones digit; bit 6 = segment a ... bit 0 = segment g.
- m_ovf  out  1  frame sum exceeded 10^D-1.
- m_valid  out  1  display word valid.
- m_ready  in  1  downstream accepts the display word.

Behaviour:
- Internal sum width W_SUM = W + $clog2(N). The sum never wraps.
- Reset: rst is sampled only on the rising edge of clk. Reset returns the FSM to ACCUM and clears cnt, sum, the BCD registers, m_valid and m_ovf. While rst is high, s_ready = 0. After reset, m_data = 0 before SEG_ACTIVE_LOW inversion. Reset overrides every other event, including in CONVERT and OUTPUT.
- State ACCUM:
  - s_ready = 1.
  - A sample is accepted when s_valid && s_ready. On acceptance: sum <= (cnt == 0) ? s_data : sum + s_data, and cnt increments.
  - If the accepted sample has cnt == N-1 or s_last = 1, the FSM moves to CONVERT and cnt clears.
  - s_valid gaps are allowed and do not affect the frame.
- State CONVERT:
  - s_ready = 0, m_valid = 0.
  - The ovf flag is registered on entry as ovf = (sum > 10^D-1).
  - The engine runs exactly W_SUM iterations, one per cycle. Each iteration adds 3 to every BCD nibble >= 5, then shifts left by one, shifting in the sum MSB first.
  - BCD register width is 4*max(D, ceil(W_SUM*log10(2))+1) bits. Only the low D digits are displayed.
  - After the last iteration the FSM moves to OUTPUT.
- State OUTPUT:
  - m_valid = 1, s_ready = 0.
  - m_data and m_ovf hold stable until m_valid && m_ready. On that transfer the FSM returns to ACCUM in the next cycle.
  - There is no overlap between a pending output and new input.
- Latency: m_valid rises exactly W_SUM+1 rising edges after the edge that accepted the final sample. Throughput is at most one frame per (frame length + W_SUM + 2) cycles.
- Overflow: if ovf = 1, every digit displays 9 and m_ovf = 1.
- Blanking (BLANK_LZ = 1): digits above the most significant nonzero digit output 7'b0000000 before inversion. Digit 0 is never blanked. No blanking is applied when ovf = 1.
- Segment table (a..g), shared with the existing display:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1110011
- s_last on a non-accepted cycle has no effect. s_last together with cnt == N-1 ends the frame once.

Decomposition:
- Package seg7_pkg:
  - typedef seg7_t (logic [6:0]) and bcd_t (logic [3:0]).
  - Constant SEG7_LUT[10].
  - Constant SEG7_BLANK.
  - FSM enum state_t {ACCUM, CONVERT, OUTPUT}.
  - Function pow10(D) for the overflow constant.
- Sub-module bin2bcd_seq (params WIN, DOUT).
  - Ports: clk, rst, start, bin, busy, done, bcd.
  - Implements the shift-add-3 iterations.
  - Top level owns the FSM, accumulator, overflow, blanking and LUT.

Test Plan:
- Default params, BLANK_LZ=1; samples 10, 20, 30, 40 then s_last -> sum 100. m_data = {0000000, 0110000, 1111110, 1111110}, m_ovf = 0. m_valid rises 13 edges after the last accept (W_SUM = 12).
- N=16 full frame of 255, no s_last -> sum 4080. Digits 4,0,8,0 = {0110011, 1111110, 1111111, 1111110}. s_ready = 0 from the 16th accept until handshake completes.
- D=2; samples 60, 40 with s_last -> m_ovf = 1, m_data = {1110011, 1110011}. Next frame 5, 4 with s_last -> {0000000, 1110011}, m_ovf = 0.
- Hold m_ready = 0 for 20 cycles in OUTPUT while driving s_valid = 1 -> m_data and m_valid stable, s_ready = 0, no sample consumed. Release -> next frame sums only new samples.
- Assert rst for one cycle mid-CONVERT -> m_valid = 0 and s_ready = 0 in that cycle, s_ready = 1 after. Frame 1, 2, 3 with s_last -> result 6, not corrupted by the prior frame.
- SEG_ACTIVE_LOW=1, single sample 7 with s_last -> digit 0 = 0001111, blanked digits = 1111111.
